// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | regfile_sb_pkg : shared defaults and address-width derivation   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package regfile_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  // Smallest w with 2**w >= nreg; NREG is a power of two so this is exact.
  function automatic int addr_width(input int nreg);
    int w;
    w = 0;
    while ((1 << w) < nreg) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_sb_bits.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sb_bits : per-register pending-write scoreboard (set/clear/flush)|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sb_bits
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW  = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            regwr,
  input  logic [AW-1:0]   rd,
  input  logic            sb_flush,
  output logic [NREG-1:0] busy,
  output logic            busy_any
);

  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;
  logic            busy_any_d;
  logic            busy_any_q;

  // Clear is applied first so a same-cycle issue to the same register wins;
  // flush then overrides everything.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (regwr && (rd == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (iss_valid && (iss_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    if (sb_flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_any_d = |busy_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  assign busy     = busy_q;
  assign busy_any = busy_any_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | regfile_sb : multi-read-port register file with write bypass    |
// |              and a pending-write scoreboard; rev 1.0            |
// +-----------------------------------------------------------------+
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  localparam int AW  = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              regwr,
  input  logic [AW-1:0]     rd,
  input  logic [XLEN-1:0]   busw,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              sb_flush,
  output logic              busy_any,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en;

  // Gated by rst so that reads stay zero for the whole reset window,
  // bypass included.
  assign wr_en = regwr && (rd != '0) && !rst;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rd] = busw;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  sb_bits #(
    .NREG (NREG)
  ) u_sb_bits (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .regwr     (regwr),
    .rd        (rd),
    .sb_flush  (sb_flush),
    .busy      (busy),
    .busy_any  (busy_any)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd_port
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = raddr[p*AW +: AW];
    assign hit  = wr_en && (rd == addr);

    // A bypassed write is the value the reader wanted, so it is not busy.
    assign rdata[p*XLEN +: XLEN] = (addr == '0) ? '0 :
                                   (hit ? busw : regs_q[addr]);
    assign rbusy[p] = busy[addr] & ~hit;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_regfile_sb : directed vector bench for regfile_sb            |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Default configuration: XLEN=32, NREG=32, NRD=2
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_regwr;
  logic [4:0]  a_rd;
  logic [31:0] a_busw;
  logic        a_iss_valid;
  logic [4:0]  a_iss_rd;
  logic        a_flush;
  logic        a_busy_any;
  logic [4:0]  a_dbg_addr;
  logic [31:0] a_dbg_data;

  // Alternate configuration: XLEN=64, NREG=16, NRD=3
  logic [11:0]  b_raddr;
  logic [191:0] b_rdata;
  logic [2:0]   b_rbusy;
  logic         b_regwr;
  logic [3:0]   b_rd;
  logic [63:0]  b_busw;
  logic         b_iss_valid;
  logic [3:0]   b_iss_rd;
  logic         b_flush;
  logic         b_busy_any;
  logic [3:0]   b_dbg_addr;
  logic [63:0]  b_dbg_data;

  regfile_sb u_dut_a (
    .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .regwr(a_regwr), .rd(a_rd), .busw(a_busw), .iss_valid(a_iss_valid),
    .iss_rd(a_iss_rd), .sb_flush(a_flush), .busy_any(a_busy_any),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_dut_b (
    .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .regwr(b_regwr), .rd(b_rd), .busw(b_busw), .iss_valid(b_iss_valid),
    .iss_rd(b_iss_rd), .sb_flush(b_flush), .busy_any(b_busy_any),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regwr;
    logic [4:0]  rd;
    logic [31:0] busw;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  dbg;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic [31:0] e_dbg;
    logic        e_any;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic a_idle();
    a_regwr = 1'b0; a_rd = '0; a_busw = '0; a_iss_valid = 1'b0; a_iss_rd = '0;
    a_flush = 1'b0; a_raddr = '0; a_dbg_addr = '0;
  endtask

  task automatic b_idle();
    b_regwr = 1'b0; b_rd = '0; b_busw = '0; b_iss_valid = 1'b0; b_iss_rd = '0;
    b_flush = 1'b0; b_raddr = '0; b_dbg_addr = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //           wr    rd     busw          iv    ird    fl    ra0    ra1    dbg    e_rd0         e_rd1         eb     e_dbg         any
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 5'd7,  32'h11111111, 1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  1'b0, 5'd5,  5'd7,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 32'h11111111, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  5'd7,  32'h0,        32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5, 1'b0};
    vecs[8]  = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd3,  1'b0, 5'd3,  5'd3,  5'd3,  32'h33333333, 32'h33333333, 2'b00, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  5'd3,  32'h33333333, 32'h0,        2'b01, 32'h33333333, 1'b1};
    vecs[10] = '{1'b1, 5'd3,  32'h44444444, 1'b0, 5'd0,  1'b0, 5'd3,  5'd5,  5'd0,  32'h44444444, 32'hDEADBEEF, 2'b00, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd5,  5'd0,  32'h44444444, 32'hDEADBEEF, 2'b00, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd4,  5'd9,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd4,  5'd9,  5'd0,  32'h0,        32'h0,        2'b01, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b1, 5'd4,  5'd9,  5'd0,  32'h0,        32'h0,        2'b11, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd2,  5'd9,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[17] = '{1'b1, 5'd9,  32'h00000099, 1'b0, 5'd0,  1'b1, 5'd9,  5'd9,  5'd9,  32'h00000099, 32'h00000099, 2'b00, 32'h0,        1'b1};
    vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  5'd9,  32'h00000099, 32'h00000099, 2'b00, 32'h00000099, 1'b0};
    vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        1'b0};

    // Reset window: a write and an issue are presented but must stay invisible.
    rst = 1'b1;
    a_idle();
    b_idle();
    a_regwr = 1'b1; a_rd = 5'd5; a_busw = 32'hFFFF0000; a_raddr = {5'd0, 5'd5};
    a_iss_valid = 1'b1; a_iss_rd = 5'd5; a_dbg_addr = 5'd5;
    b_raddr = {4'd1, 4'd2, 4'd3};
    #2;
    check("rst a_rdata", a_rdata, 64'h0);
    check("rst a_rbusy", {62'h0, a_rbusy}, 64'h0);
    check("rst a_dbg", {32'h0, a_dbg_data}, 64'h0);
    check("rst a_busy_any", {63'h0, a_busy_any}, 64'h0);
    check("rst b_rdata_lo", b_rdata[63:0], 64'h0);
    check("rst b_busy_any", {63'h0, b_busy_any}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    a_idle();
    #1;
    check("post-rst discarded write", a_rdata[31:0], 64'h0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      a_regwr = vecs[i].regwr; a_rd = vecs[i].rd; a_busw = vecs[i].busw;
      a_iss_valid = vecs[i].iss_valid; a_iss_rd = vecs[i].iss_rd;
      a_flush = vecs[i].flush; a_raddr = {vecs[i].ra1, vecs[i].ra0};
      a_dbg_addr = vecs[i].dbg;
      #3;
      check($sformatf("v%0d rdata0", i), {32'h0, a_rdata[31:0]}, {32'h0, vecs[i].e_rd0});
      check($sformatf("v%0d rdata1", i), {32'h0, a_rdata[63:32]}, {32'h0, vecs[i].e_rd1});
      check($sformatf("v%0d rbusy", i), {62'h0, a_rbusy}, {62'h0, vecs[i].e_busy});
      check($sformatf("v%0d dbg", i), {32'h0, a_dbg_data}, {32'h0, vecs[i].e_dbg});
      check($sformatf("v%0d busy_any", i), {63'h0, a_busy_any}, {63'h0, vecs[i].e_any});
    end

    // Async reset mid-cycle on both configurations.
    @(negedge clk);
    a_idle();
    a_regwr = 1'b1; a_rd = 5'd10; a_busw = 32'hCAFEF00D;
    b_regwr = 1'b1; b_rd = 4'd10; b_busw = 64'h0123456789ABCDEF;
    b_iss_valid = 1'b1; b_iss_rd = 4'd15;
    @(negedge clk);
    a_idle();
    b_idle();
    a_raddr = {5'd0, 5'd10};
    a_dbg_addr = 5'd10;
    b_raddr = {4'd15, 4'd10, 4'd10};
    b_dbg_addr = 4'd10;
    #1;
    check("s6 a r10", {32'h0, a_rdata[31:0]}, 64'hCAFEF00D);
    check("s6 b r10 p0", b_rdata[63:0], 64'h0123456789ABCDEF);
    check("s6 b r10 p1", b_rdata[127:64], 64'h0123456789ABCDEF);
    check("s6 b dbg", b_dbg_data, 64'h0123456789ABCDEF);
    check("s6 b rbusy", {61'h0, b_rbusy}, 64'h4);
    check("s6 b busy_any", {63'h0, b_busy_any}, 64'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    a_regwr = 1'b1; a_rd = 5'd10; a_busw = 32'h55555555;
    a_iss_valid = 1'b1; a_iss_rd = 5'd10;
    #1;
    check("s6 async a r10", {32'h0, a_rdata[31:0]}, 64'h0);
    check("s6 async a dbg", {32'h0, a_dbg_data}, 64'h0);
    check("s6 async b rdata", b_rdata[127:0], 64'h0);
    check("s6 async b p2", b_rdata[191:128], 64'h0);
    check("s6 async b dbg", b_dbg_data, 64'h0);
    check("s6 async b rbusy", {61'h0, b_rbusy}, 64'h0);
    check("s6 async b busy_any", {63'h0, b_busy_any}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_regwr = 1'b0; a_iss_valid = 1'b0;
    #1;
    check("s6 in-flight discarded", {32'h0, a_rdata[31:0]}, 64'h0);
    check("s6 in-flight issue discarded", {63'h0, a_busy_any}, 64'h0);
    a_regwr = 1'b1; a_rd = 5'd10; a_busw = 32'h00000077;
    #1;
    check("s6 first write bypass", {32'h0, a_rdata[31:0]}, 64'h77);
    @(negedge clk);
    a_regwr = 1'b0;
    #1;
    check("s6 first write stored", {32'h0, a_dbg_data}, 64'h77);
    check("s6 b r10 after rst", b_rdata[63:0], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
